andor_pulse_monitor: RTL



---
 rtl/andor_pulse_monitor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/andor_pulse_monitor.sv
// andor_pulse_monitor: measures the synchronized Y output of an AND-OR gate
// stage over a programmable window. It counts high cycles, rising edges and
// falling edges, then reports them with a one-cycle done pulse.
// Optional longest-high-run tracking is enabled by defining ANDOR_MON_MAXRUN_EN.
// When it is undefined, max_run is tied to zero.
module andor_pulse_monitor #(
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 8,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic [CNT_W-1:0] max_run
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y_s;
    logic                   y_prev_q;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [CNT_W-1:0]       rise_q, rise_d;
    logic [CNT_W-1:0]       fall_q, fall_d;
    logic                   accept;
    logic                   measuring;

    // Saturating increment: the value sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    assign y_s       = sync_q[SYNC_STAGES-1];
    assign accept    = (state_q == ST_IDLE) && start && (window_len != '0);
    assign measuring = (state_q == ST_MEASURE);

    // Synchronize asynchronous y_in and keep the previous synchronized sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            y_prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, which keeps the shift chain ordered.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], y_in};
            y_prev_q <= y_s;
        end
    end

    // State, window counter and result counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            high_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            high_q    <= high_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    // Next-state logic: accept a start request, sample each window cycle, and pulse done.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path can leave
        // a signal unassigned and infer a latch.
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        high_d    = high_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_MEASURE;
                    win_cnt_d = window_len;
                    high_d    = '0;
                    rise_d    = '0;
                    fall_d    = '0;
                end
            end
            ST_MEASURE: begin
                high_d    = sat_inc(high_q, y_s);
                rise_d    = sat_inc(rise_q, y_s & ~y_prev_q);
                fall_d    = sat_inc(fall_q, ~y_s & y_prev_q);
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q == ST_MEASURE);
    assign done       = (state_q == ST_DONE);
    assign high_count = high_q;
    assign rise_count = rise_q;
    assign fall_count = fall_q;

`ifdef ANDOR_MON_MAXRUN_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] run_inc;

    assign run_inc = sat_inc(run_q, 1'b1);

    // Run tracking: extend the current high run, and remember the longest one.
    always_comb begin
        run_d = run_q;
        max_d = max_q;
        if (accept) begin
            run_d = '0;
            max_d = '0;
        end else if (measuring) begin
            if (y_s) begin
                run_d = run_inc;
                if (run_inc > max_q) begin
                    max_d = run_inc;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    // Run registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            max_q <= '0;
        end else begin
            run_q <= run_d;
            max_q <= max_d;
        end
    end

    assign max_run = max_q;
`else
    assign max_run = '0;
`endif

endmodule
